// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the core's memory stage
// and the data-memory responder. The core drives the master side.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder in front of a
// word-wide block RAM. Stores are lane-aligned and written at acceptance;
// loads return sub-word extracted, sign/zero-extended data two cycles later.
// Optional feature macro: DMEM_ERR_CHECK_EN enables access-error detection;
// without it, misaligned accesses are forced to natural alignment, size 3
// behaves as word and the address wraps modulo the RAM depth.
module dmem_responder #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   logic [1:0]        state;
   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       rd_word;

   logic [1:0]        eff_size;
   logic [1:0]        eff_off;
   logic              req_err;
   logic [3:0]        lane_mask;
   logic [31:0]       wr_data;
   logic [ADDR_W-1:0] word_idx;
   logic              xfer;
   logic              ram_we;
   logic              ram_re;

   logic [1:0]        lat_size;
   logic              lat_uns;
   logic [1:0]        lat_off;
   logic [31:0]       rd_shifted;
   logic [31:0]       load_ext;
   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;

   assign bus.req_ready  = (state == S_IDLE) && !rst;
   assign bus.resp_valid = (state == S_RESP);
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

   assign xfer     = bus.req_valid && bus.req_ready;
   assign ram_we   = xfer && bus.req_we && !req_err;
   assign ram_re   = xfer && !bus.req_we && !req_err;
   assign word_idx = bus.req_addr[ADDR_W+1:2];
   assign wr_data  = bus.req_wdata << {eff_off, 3'b000};

`ifndef DMEM_ERR_CHECK_EN
   // Upper address bits are deliberately ignored when the address wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
`endif

   // Decode the effective access size, byte offset and error status of the request.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      eff_size = bus.req_size;
      eff_off  = bus.req_addr[1:0];
      req_err  = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
      req_err = (bus.req_size == 2'd3)
             || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
             || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
             || (bus.req_addr[31:ADDR_W+2] != '0);
`else
      case (bus.req_size)
         SZ_BYTE: eff_off = bus.req_addr[1:0];
         SZ_HALF: eff_off = {bus.req_addr[1], 1'b0};
         default: begin
            eff_size = SZ_WORD;
            eff_off  = 2'b00;
         end
      endcase
`endif
   end

   // Byte-lane enables for the store, shifted to the addressed lane.
   always_comb begin
      case (eff_size)
         SZ_BYTE: lane_mask = 4'b0001 << eff_off;
         SZ_HALF: lane_mask = 4'b0011 << eff_off;
         default: lane_mask = 4'b1111;
      endcase
   end

   // Block RAM: lane-masked write at store acceptance, registered read at load acceptance.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array is never reset so it maps onto block RAM; contents survive rst.
      for (int b = 0; b < 4; b++) begin
         if (ram_we && lane_mask[b]) begin
            mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
      if (ram_re) begin
         rd_word <= mem[word_idx];
      end
   end

   // Extract the addressed bytes from the RAM word and extend to 32 bits.
   always_comb begin
      rd_shifted = rd_word >> {lat_off, 3'b000};
      case (lat_size)
         SZ_BYTE: load_ext = lat_uns ? {24'h0, rd_shifted[7:0]}
                                     : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         SZ_HALF: load_ext = lat_uns ? {16'h0, rd_shifted[15:0]}
                                     : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         default: load_ext = rd_shifted;
      endcase
   end

   // Request/response sequencing: IDLE accepts, READ formats load data, RESP holds until consumed.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state        <= S_IDLE;
         lat_size     <= SZ_BYTE;
         lat_uns      <= 1'b0;
         lat_off      <= 2'b00;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  lat_size     <= eff_size;
                  lat_uns      <= bus.req_unsigned;
                  lat_off      <= eff_off;
                  resp_rdata_q <= 32'h0;
                  resp_err_q   <= req_err;
                  state        <= ram_re ? S_READ : S_RESP;
               end
            end
            S_READ: begin
               resp_rdata_q <= load_ext;
               state        <= S_RESP;
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test-plan scenarios plus randomized traffic,
// checked against a byte-addressed reference memory model.
module tb_dmem_responder;

   localparam int ADDR_W      = 12;
   localparam int DEPTH_BYTES = 4 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0] ref_mem [DEPTH_BYTES];

   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(.ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference behaviour: byte-addressed memory, access rules applied arithmetically.
   function automatic void model_access(input logic we, input logic [1:0] size, input logic uns,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        output logic [31:0] rdata, output logic err);
      int unsigned nb;
      int unsigned a;
      logic [31:0] v;
      nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      rdata = 32'h0;
`ifdef DMEM_ERR_CHECK_EN
      err = (size == 2'd3) || (addr % nb != 0) || (addr >= DEPTH_BYTES);
      if (err) return;
      a = addr;
`else
      err = 1'b0;
      a   = addr % DEPTH_BYTES;
      a   = a - (a % nb);
`endif
      if (we) begin
         for (int i = 0; i < int'(nb); i++) ref_mem[a + i] = wdata[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < int'(nb); i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
         if (!uns && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         rdata = v;
      end
   endfunction

   // One complete transaction: handshake, latency, response, optional stall, release.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         output logic [31:0] got, output logic got_err);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          lat;
      int          wait_n;
      model_access(we, size, uns, addr, wdata, exp_rd, exp_err);
      @(negedge clk);
      wait_n = 0;
      while (!bus.req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), (we || exp_err) ? 32'd1 : 32'd2);
      check({tag, ".rdata"}, bus.resp_rdata, exp_rd);
      check({tag, ".err"}, 32'(bus.resp_err), 32'(exp_err));
      got     = bus.resp_rdata;
      got_err = bus.resp_err;
      for (int s = 0; s < stall; s++) begin
         // A store presented while busy must be ignored.
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b1;
         bus.req_size  = 2'd2;
         bus.req_addr  = {24'h0, 6'($urandom), 2'b00};
         bus.req_wdata = $urandom;
         @(negedge clk);
         check({tag, ".stall_valid"}, 32'(bus.resp_valid), 32'd1);
         check({tag, ".stall_rdata"}, bus.resp_rdata, exp_rd);
         check({tag, ".stall_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      check({tag, ".ready_after"}, 32'(bus.req_ready), 32'd1);
      check({tag, ".valid_after"}, 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic        got_err;
      logic [31:0] addr;
      logic [1:0]  size;

      for (int i = 0; i < DEPTH_BYTES; i++) ref_mem[i] = 8'h00;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.resp_ready   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst.req_ready", 32'(bus.req_ready), 32'd0);
      check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst.resp_rdata", bus.resp_rdata, 32'h0);
      check("rst.resp_err", 32'(bus.resp_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst.ready_after", 32'(bus.req_ready), 32'd1);

      // Initialise the exercised region so every load has a defined answer.
      for (int w = 0; w < 64; w++)
         do_req("fill", 1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, 0, got, got_err);

      // Word store then load
      do_req("w_st", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got, got_err);
      do_req("w_ld", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got, got_err);
      check("w_ld.const", got, 32'hDEADBEEF);

      // Byte store into a word, sign/zero-extended byte loads
      do_req("w_st2", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, got, got_err);
      do_req("b_st", 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, 0, got, got_err);
      do_req("w_ld2", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got, got_err);
      check("w_ld2.const", got, 32'hAA223344);
      do_req("lb", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, got, got_err);
      check("lb.const", got, 32'hFFFFFFAA);
      do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, got, got_err);
      check("lbu.const", got, 32'h000000AA);

      // Half store into the upper half of a word
      do_req("h_st", 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 0, got, got_err);
      do_req("lh", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, got, got_err);
      check("lh.const", got, 32'hFFFF8001);
      do_req("lhu", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0, got, got_err);
      check("lhu.const", got, 32'h00008001);
      do_req("w_ld20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, got, got_err);

      // Misaligned and out-of-range accesses (rejected, or aligned/wrapped)
      do_req("mis_ld", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0, got, got_err);
`ifdef DMEM_ERR_CHECK_EN
      check("mis_ld.err_const", 32'(got_err), 32'd1);
      check("mis_ld.rdata_const", got, 32'h0);
`endif
      do_req("mis_st", 1'b1, 2'd2, 1'b0, 32'h11, 32'h55667788, 0, got, got_err);
      do_req("mis_chk", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got, got_err);
      do_req("oor_ld", 1'b0, 2'd2, 1'b0, 32'h00004000, 32'h0, 0, got, got_err);
      do_req("sz3_ld", 1'b0, 2'd3, 1'b0, 32'h24, 32'h0, 0, got, got_err);

      // Stalled response with ignored requests while busy
      do_req("w_st3", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, got, got_err);
      do_req("stall_ld", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, got, got_err);
      check("stall_ld.const", got, 32'hDEADBEEF);

      // Reset while a load is in READ: the load must be dropped
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd2;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h10;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst.req_ready", 32'(bus.req_ready), 32'd0);
      check("midrst.resp_valid", 32'(bus.resp_valid), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst.no_resp", 32'(bus.resp_valid), 32'd0);
      end
      do_req("post_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got, got_err);
      check("post_rst.const", got, 32'hDEADBEEF);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         addr = 32'($urandom_range(0, 255));
         case ($urandom_range(0, 9))
            0: addr = addr | 32'h0000_4000;
            1: addr = addr | 32'h8000_0000;
            default: ;
         endcase
         size = 2'($urandom_range(0, 3));
         do_req("rnd", 1'($urandom), size, 1'($urandom), addr, $urandom,
                int'($urandom_range(0, 2)), got, got_err);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
